// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM states, decode helper.
// MDU_MADD_EN enables the multiply-accumulate op codes.
package mdu_pkg;

  localparam logic [3:0] NOP   = 4'd0;
  localparam logic [3:0] MULT  = 4'd1;
  localparam logic [3:0] MULTU = 4'd2;
  localparam logic [3:0] DIV   = 4'd3;
  localparam logic [3:0] DIVU  = 4'd4;
  localparam logic [3:0] MTHI  = 4'd5;
  localparam logic [3:0] MTLO  = 4'd6;
  localparam logic [3:0] MFHI  = 4'd7;
  localparam logic [3:0] MFLO  = 4'd8;
  localparam logic [3:0] MADD  = 4'd9;
  localparam logic [3:0] MADDU = 4'd10;
  localparam logic [3:0] MSUB  = 4'd11;
  localparam logic [3:0] MSUBU = 4'd12;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  // D-stage decoder uses this to route an instruction through the busy/start interlock.
  function automatic logic is_mdu_class(input logic [3:0] op);
    logic r;
    r = (op >= MULT) && (op <= MFLO);
`ifdef MDU_MADD_EN
    r = r || ((op >= MADD) && (op <= MSUBU));
`endif
    return r;
  endfunction

endpackage

// File: rtl/mdu_latency_ctr.sv
// Loadable down-counter; o_done is high while the count sits at 1, i.e. the last busy cycle.
module mdu_latency_ctr #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  output logic          o_done
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset)               r_cnt <= '0;
    else if (i_load)         r_cnt <= i_load_val;
    else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
  end

  assign o_done = (r_cnt == CW'(1));

endmodule

// File: rtl/mdu_unit.sv
// EX-stage multiply/divide unit owning HI/LO; results are computed at issue and committed after the op latency.
// Optional macro MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU accumulating into {HI,LO}.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic             start,
  input  logic             cancel,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_LAT + 1);

  // Handshake: start is a one-cycle request, honoured only when busy=0 and cancel=0.
  mdu_state_e         r_state, w_state_next;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic [2*WIDTH-1:0] r_pend;
  logic               r_wr;
  logic               w_accept, w_is_mul, w_is_div, w_signed, w_done;
  logic               w_load;
  logic [CW-1:0]      w_load_val;

  always_comb begin
    w_is_mul = (op == MULT) || (op == MULTU);
    w_is_div = (op == DIV) || (op == DIVU);
    w_signed = (op == MULT) || (op == DIV);
`ifdef MDU_MADD_EN
    w_is_mul = w_is_mul || (op == MADD) || (op == MADDU) || (op == MSUB) || (op == MSUBU);
    w_signed = w_signed || (op == MADD) || (op == MSUB);
`endif
  end

  assign w_accept = start && !cancel && (r_state == S_IDLE);

  // Single 2W-bit multiplier; sign handling is folded into the operand extension.
  logic [2*WIDTH-1:0] w_ext_a, w_ext_b, w_prod;
  assign w_ext_a = {{WIDTH{w_signed & src_a[WIDTH-1]}}, src_a};
  assign w_ext_b = {{WIDTH{w_signed & src_b[WIDTH-1]}}, src_b};
  assign w_prod  = w_ext_a * w_ext_b;

  // Magnitude divide then re-sign; most-negative / -1 falls out as lo=most-negative, hi=0.
  logic             w_a_neg, w_b_neg, w_div_zero;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_divisor, w_q_mag, w_r_mag, w_quo, w_rem;
  assign w_a_neg    = w_signed & src_a[WIDTH-1];
  assign w_b_neg    = w_signed & src_b[WIDTH-1];
  assign w_abs_a    = w_a_neg ? (~src_a + 1'b1) : src_a;
  assign w_abs_b    = w_b_neg ? (~src_b + 1'b1) : src_b;
  assign w_div_zero = (src_b == '0);
  assign w_divisor  = w_div_zero ? WIDTH'(1) : w_abs_b;
  assign w_q_mag    = w_abs_a / w_divisor;
  assign w_r_mag    = w_abs_a % w_divisor;
  assign w_quo      = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 1'b1) : w_q_mag;
  assign w_rem      = w_a_neg ? (~w_r_mag + 1'b1) : w_r_mag;

  mdu_latency_ctr #(.CW(CW)) u_ctr (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_val   = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept && (w_is_mul || w_is_div)) begin
          w_state_next = S_RUN;
          w_load       = 1'b1;
          w_load_val   = w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end
      end
      S_RUN: begin
        if (w_done) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

`ifdef MDU_MADD_EN
  logic               r_acc, r_sub;
  logic [2*WIDTH-1:0] w_acc_res;
  assign w_acc_res = r_sub ? ({r_hi, r_lo} - r_pend) : ({r_hi, r_lo} + r_pend);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
      r_wr   <= 1'b0;
`ifdef MDU_MADD_EN
      r_acc  <= 1'b0;
      r_sub  <= 1'b0;
`endif
    end else if (w_load) begin
      r_pend <= w_is_div ? {w_rem, w_quo} : w_prod;
      r_wr   <= !(w_is_div && w_div_zero);
`ifdef MDU_MADD_EN
      r_acc  <= (op == MADD) || (op == MADDU) || (op == MSUB) || (op == MSUBU);
      r_sub  <= (op == MSUB) || (op == MSUBU);
`endif
    end
  end

  // Accumulation reads {HI,LO} at commit time, not at issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if ((r_state == S_RUN) && w_done) begin
`ifdef MDU_MADD_EN
      if (r_acc)     {r_hi, r_lo} <= w_acc_res;
      else if (r_wr) {r_hi, r_lo} <= r_pend;
`else
      if (r_wr)      {r_hi, r_lo} <= r_pend;
`endif
    end else if (w_accept && (op == MTHI)) begin
      r_hi <= src_a;
    end else if (w_accept && (op == MTLO)) begin
      r_lo <= src_a;
    end
  end

  assign busy = (r_state == S_RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit with hand-computed HI/LO and latency expectations.
// Build with MDU_MADD_EN to exercise the accumulate ops instead of their no-op behaviour.
module tb_mdu_unit;
  import mdu_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  op = NOP;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        busy;
  logic [31:0] hi, lo;

  int n_total = 0;
  int n_bad   = 0;

  mdu_unit #(.WIDTH(32), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk    (clk),
    .reset  (reset),
    .op     (op),
    .start  (start),
    .cancel (cancel),
    .src_a  (src_a),
    .src_b  (src_b),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drives start for one cycle; returns at the negedge of the first cycle after issue.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic c);
    @(negedge clk);
    op = o; src_a = a; src_b = b; cancel = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; op = NOP;
  endtask

  task automatic count_busy(input string tag, input int lat);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_lat"}, 32'(n), 32'(lat));
  endtask

  task automatic run_long(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int lat,
                          input logic [31:0] eh, input logic [31:0] el);
    issue(o, a, b, 1'b0);
    count_busy(tag, lat);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);

    run_long("mult_neg", MULT, 32'hFFFF_FFFD, 32'd7, MULT_N, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_long("multu_big", MULTU, 32'hFFFF_FFFF, 32'd2, MULT_N, 32'h0000_0001, 32'hFFFF_FFFE);
    run_long("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, DIV_N, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_long("div_negb", DIV, 32'd7, 32'hFFFF_FFFE, DIV_N, 32'h0000_0001, 32'hFFFF_FFFD);
    run_long("divu", DIVU, 32'd7, 32'd2, DIV_N, 32'd1, 32'd3);
    run_long("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 32'h0, 32'h8000_0000);

    issue(MTHI, 32'h1234, 32'h0, 1'b0);
    check("mthi_busy", 32'(busy), 32'd0);
    check("mthi_hi", hi, 32'h1234);
    check("mthi_lo", lo, 32'h8000_0000);
    issue(MTHI, 32'h5678, 32'h0, 1'b1);
    check("mthi_cancel_hi", hi, 32'h1234);
    issue(MULT, 32'd5, 32'd5, 1'b1);
    check("mult_cancel_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("mult_cancel_hi", hi, 32'h1234);
    check("mult_cancel_lo", lo, 32'h8000_0000);
    issue(MFLO, 32'hAAAA, 32'hBBBB, 1'b0);
    check("mflo_busy", 32'(busy), 32'd0);
    check("mflo_lo", lo, 32'h8000_0000);

    issue(MTHI, 32'd5, 32'd0, 1'b0);
    issue(MTLO, 32'd9, 32'd0, 1'b0);
    run_long("divz", DIVU, 32'd77, 32'd0, DIV_N, 32'd5, 32'd9);

    issue(DIVU, 32'd7, 32'd2, 1'b0);
    check("ign_busy", 32'(busy), 32'd1);
    op = MULT; src_a = 32'hFFFF_FFFD; src_b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = NOP;
    count_busy("ign", DIV_N - 1);
    check("ign_hi", hi, 32'd1);
    check("ign_lo", lo, 32'd3);

    issue(MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_hi", hi, 32'h0);
    check("mrst_lo", lo, 32'h0);
    repeat (MULT_N + 3) @(negedge clk);
    check("mrst_late_hi", hi, 32'h0);
    check("mrst_late_lo", lo, 32'h0);
    check("mrst_late_busy", 32'(busy), 32'd0);

    issue(MTHI, 32'h0, 32'h0, 1'b0);
    issue(MTLO, 32'hFFFF_FFFF, 32'h0, 1'b0);
`ifdef MDU_MADD_EN
    run_long("maddu", MADDU, 32'd1, 32'd1, MULT_N, 32'd1, 32'd0);
    run_long("msub", MSUB, 32'd2, 32'd3, MULT_N, 32'd0, 32'hFFFF_FFFA);
    run_long("madd_neg", MADD, 32'hFFFF_FFFF, 32'd1, MULT_N, 32'd0, 32'hFFFF_FFF9);
`else
    issue(MADDU, 32'd1, 32'd1, 1'b0);
    check("maddu_off_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("maddu_off_busy2", 32'(busy), 32'd0);
    check("maddu_off_hi", hi, 32'h0);
    check("maddu_off_lo", lo, 32'hFFFF_FFFF);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
